mmr_scrub_register: RTL and testbench
=====================================

// Module: mmr_scrub_register
// PURPOSE
//  Parametrised K-modular-redundant WIDTH-bit register bank with bitwise majority voting.
//  Adds periodic scrubbing that writes the voted value back into every replica.
//  Provides per-replica sticky error flags, a saturating correction counter and a
//  fault-injection port. Sits behind the MMR config/status bus; q_o feeds datapath config.
// PARAMETERS
//  WIDTH        16  data width of each replica
//  K_MMR        3   number of replicas; odd, >=3 (elaboration $error otherwise)
//  RESET_VALUE  0   reset value of every replica (WIDTH bits)
//  SCRUB_PERIOD 16  cycles between scrub checks; >=1 (1 = check every cycle)
//  CNT_WIDTH    8   width of correction counter
//  MISMATCH_EN  1   1: mismatch_o live; 0: mismatch_o tied 0
//  INJ_EN       1   1: injection port active; 0: inj_* ignored (synthesis build)
// PORTS
//  clk_i        in   1                  clock
//  rst_i        in   1                  asynchronous reset, active-low
//  wr_valid_i   in   1                  write request
//  wr_ready_o   out  1                  write accept; transfer when valid&ready
//  wr_data_i    in   WIDTH              write data
//  inj_valid_i  in   1                  fault-injection strobe
//  inj_rep_i    in   $clog2(K_MMR)      replica index to corrupt
//  inj_mask_i   in   WIDTH              XOR mask applied to that replica
//  q_o          out  WIDTH              bitwise majority of replicas
//  mismatch_o   out  1                  any replica bit differs from vote
//  corrected_o  out  1                  1-cycle pulse when a correction is written back
//  err_rep_o    out  K_MMR              sticky: replica k disagreed at a scrub write-back
//  err_clr_i    in   1                  clears err_rep_o and corr_cnt_o
//  corr_cnt_o   out  CNT_WIDTH          number of corrections, saturating
// BEHAVIOUR
//  Reset (rst_i=0, async): replicas=RESET_VALUE, state=IDLE, timer=0, corr_cnt_o=0,
//   err_rep_o=0, corrected_o=0; wr_ready_o=1 from first cycle after release.
//  Vote: q_o/mismatch_o combinational from replica flops; bit b =1 iff >(K_MMR-1)/2 replicas =1.
//  Write: accepted edge loads wr_data_i into all replicas; q_o updates next cycle (latency 1).
//  Timer: free-running 0..SCRUB_PERIOD-1 in IDLE; "tick" when timer==SCRUB_PERIOD-1.
//  FSM IDLE: wr_ready_o=1. On tick & mismatch & no accepted write -> CORRECT; timer->0.
//   Tick with accepted write: write wins, no correction, timer wraps to 0.
//  FSM CORRECT (exactly 1 cycle): wr_ready_o=0; all replicas <= q_o; corrected_o=1;
//   err_rep_o[k] |= (replica k != q_o); corr_cnt_o+1 unless all-ones -> IDLE.
//  Injection (INJ_EN=1): inj_valid_i in IDLE with no accepted write -> replica[inj_rep_i]
//   ^= inj_mask_i. Priority: write > CORRECT write-back > injection (lower dropped, not queued).
//   inj_rep_i >= K_MMR: ignored.
//  err_clr_i: clears err_rep_o/corr_cnt_o next edge; same-cycle correction wins (flags set, cnt=1).
//  Multi-replica corruption of the same bit beyond minority is miscorrected silently (by design).
//  Reset mid-CORRECT: async restore; no corrected_o pulse emitted.
// TESTING
//  Reset: rst_i low 3 cyc -> q_o=RESET_VALUE, wr_ready_o=1, corr_cnt_o=0, err_rep_o=0.
//  Write 16'hA5C3 -> q_o=16'hA5C3 next cycle, mismatch_o=0, no corrected_o.
//  Inject rep1 mask 16'h0001 -> mismatch_o=1, q_o unchanged; at next tick corrected_o=1,
//   err_rep_o=3'b010, corr_cnt_o=1, mismatch_o=0 following cycle.
//  Inject then write 16'h1234 on tick cycle -> replicas=16'h1234, no correction, cnt unchanged.
//  CNT_WIDTH=2, 5 inject/scrub rounds -> corr_cnt_o saturates at 3; err_clr_i -> 0.
//  Write held in CORRECT: wr_ready_o=0, write accepted next cycle, data not lost.

Source files
------------

// File: rtl/mmr_scrub_register.sv
// K-modular-redundant register bank: bitwise majority vote, periodic scrub
// write-back, sticky per-replica error flags, saturating correction counter
// and a fault-injection port.
module mmr_scrub_register #(
    parameter int unsigned       WIDTH        = 16,
    parameter int unsigned       K_MMR        = 3,
    parameter logic [WIDTH-1:0]  RESET_VALUE  = '0,
    parameter int unsigned       SCRUB_PERIOD = 16,
    parameter int unsigned       CNT_WIDTH    = 8,
    parameter bit                MISMATCH_EN  = 1'b1,
    parameter bit                INJ_EN       = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wr_valid_i,
    output logic                       wr_ready_o,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       inj_valid_i,
    input  logic [$clog2(K_MMR)-1:0]   inj_rep_i,
    input  logic [WIDTH-1:0]           inj_mask_i,
    output logic [WIDTH-1:0]           q_o,
    output logic                       mismatch_o,
    output logic                       corrected_o,
    output logic [K_MMR-1:0]           err_rep_o,
    input  logic                       err_clr_i,
    output logic [CNT_WIDTH-1:0]       corr_cnt_o
);

    localparam int unsigned REP_W  = $clog2(K_MMR);
    localparam int unsigned TMR_W  = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;
    localparam int unsigned VCNT_W = $clog2(K_MMR + 1);
    localparam int unsigned MAJ    = (K_MMR - 1) / 2;

    // Reject configurations the vote cannot handle
    if (K_MMR < 3 || (K_MMR % 2) == 0) begin : g_bad_k
        $error("mmr_scrub_register: K_MMR must be odd and >= 3");
    end
    if (SCRUB_PERIOD < 1) begin : g_bad_period
        $error("mmr_scrub_register: SCRUB_PERIOD must be >= 1");
    end

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_CORRECT = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic [WIDTH-1:0]       rep_q [K_MMR];
    logic [WIDTH-1:0]       rep_d [K_MMR];
    logic [K_MMR-1:0]       err_q, err_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

    logic [WIDTH-1:0]       vote;
    logic [VCNT_W-1:0]      ones;
    logic [K_MMR-1:0]       diff;
    logic                   mism_raw;
    logic                   wr_fire;
    logic                   tick;

    // Bitwise majority across replicas
    always_comb begin
        vote = '0;
        ones = '0;
        for (int unsigned b = 0; b < WIDTH; b++) begin
            ones = '0;
            for (int unsigned k = 0; k < K_MMR; k++) begin
                ones = ones + VCNT_W'(rep_q[k][b]);
            end
            vote[b] = (ones > VCNT_W'(MAJ));
        end
    end

    // Per-replica disagreement with the vote
    always_comb begin
        diff = '0;
        for (int unsigned k = 0; k < K_MMR; k++) begin
            diff[k] = (rep_q[k] != vote);
        end
    end

    assign mism_raw    = |diff;
    assign q_o         = vote;
    assign mismatch_o  = MISMATCH_EN ? mism_raw : 1'b0;
    assign wr_ready_o  = (state_q == S_IDLE);
    assign corrected_o = (state_q == S_CORRECT);
    assign err_rep_o   = err_q;
    assign corr_cnt_o  = cnt_q;
    assign wr_fire     = wr_valid_i & wr_ready_o;
    assign tick        = (timer_q == TMR_W'(SCRUB_PERIOD - 1));

    // Next-state: scrub FSM, timer, replicas, error flags and counter
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        rep_d   = rep_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (tick) begin
                    timer_d = '0;
                    if (mism_raw && !wr_fire) begin
                        state_d = S_CORRECT;
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_CORRECT: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
            default: state_d = S_IDLE;
        endcase

        // Write beats scrub write-back beats injection; losers are dropped
        if (wr_fire) begin
            for (int unsigned k = 0; k < K_MMR; k++) rep_d[k] = wr_data_i;
        end else if (state_q == S_CORRECT) begin
            for (int unsigned k = 0; k < K_MMR; k++) rep_d[k] = vote;
        end else if (INJ_EN && inj_valid_i) begin
            // Out-of-range indices match no replica and are ignored
            for (int unsigned k = 0; k < K_MMR; k++) begin
                if (inj_rep_i == REP_W'(k)) rep_d[k] = rep_q[k] ^ inj_mask_i;
            end
        end

        // A correction in the clearing cycle survives the clear
        if (state_q == S_CORRECT) begin
            if (err_clr_i) begin
                err_d = diff;
                cnt_d = CNT_WIDTH'(1);
            end else begin
                err_d = err_q | diff;
                if (cnt_q != {CNT_WIDTH{1'b1}}) cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end else if (err_clr_i) begin
            err_d = '0;
            cnt_d = '0;
        end
    end

    // State and storage registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            err_q   <= '0;
            cnt_q   <= '0;
            for (int unsigned k = 0; k < K_MMR; k++) rep_q[k] <= RESET_VALUE;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            for (int unsigned k = 0; k < K_MMR; k++) rep_q[k] <= rep_d[k];
        end
    end

endmodule

// File: tb/tb_mmr_scrub_register.sv
// Bench for mmr_scrub_register: cycle model plus directed scenarios.
module tb_mmr_scrub_register;

    localparam int unsigned SP   = 5;
    localparam logic [15:0] RSTV = 16'h5A0F;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [15:0] wr_data = '0;
    logic        inj_valid = 1'b0;
    logic [1:0]  inj_rep = '0;
    logic [15:0] inj_mask = '0;
    logic [15:0] q;
    logic        mismatch;
    logic        corrected;
    logic [2:0]  err_rep;
    logic        err_clr = 1'b0;
    logic [1:0]  corr_cnt;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    mmr_scrub_register #(
        .WIDTH(16), .K_MMR(3), .RESET_VALUE(RSTV), .SCRUB_PERIOD(SP),
        .CNT_WIDTH(2), .MISMATCH_EN(1'b1), .INJ_EN(1'b1)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data),
        .inj_valid_i(inj_valid), .inj_rep_i(inj_rep), .inj_mask_i(inj_mask),
        .q_o(q), .mismatch_o(mismatch), .corrected_o(corrected),
        .err_rep_o(err_rep), .err_clr_i(err_clr), .corr_cnt_o(corr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] m_rep [3];
    bit          m_corr;
    int          m_timer;
    logic [2:0]  m_err;
    int          m_cnt;

    function automatic logic [15:0] vote3(input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] c);
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = ($countones({a[i], b[i], c[i]}) >= 2);
        return v;
    endfunction

    function automatic logic [2:0] disagree(input logic [15:0] a, input logic [15:0] b,
                                            input logic [15:0] c);
        logic [15:0] v;
        v = vote3(a, b, c);
        return {c != v, b != v, a != v};
    endfunction

    always @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            for (int k = 0; k < 3; k++) m_rep[k] = RSTV;
            m_corr = 1'b0; m_timer = 0; m_err = '0; m_cnt = 0;
        end else begin
            logic [15:0] v;
            logic [2:0]  d;
            bit          wfire;
            bit          due;
            v     = vote3(m_rep[0], m_rep[1], m_rep[2]);
            d     = disagree(m_rep[0], m_rep[1], m_rep[2]);
            wfire = wr_valid && !m_corr;
            due   = (m_timer == SP - 1);
            if (m_corr) begin
                m_err = err_clr ? d : (m_err | d);
                m_cnt = err_clr ? 1 : ((m_cnt + 1 > 3) ? 3 : m_cnt + 1);
            end else if (err_clr) begin
                m_err = '0; m_cnt = 0;
            end
            if (wfire) begin
                for (int k = 0; k < 3; k++) m_rep[k] = wr_data;
            end else if (m_corr) begin
                for (int k = 0; k < 3; k++) m_rep[k] = v;
            end else if (inj_valid && inj_rep < 2'd3) begin
                m_rep[inj_rep] = m_rep[inj_rep] ^ inj_mask;
            end
            if (m_corr) begin
                m_corr = 1'b0; m_timer = 0;
            end else if (due) begin
                m_timer = 0; m_corr = (d != 3'b000) && !wfire;
            end else begin
                m_timer = m_timer + 1;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("q_o", 32'(q), 32'(vote3(m_rep[0], m_rep[1], m_rep[2])));
            chk("mismatch_o", 32'(mismatch), 32'(disagree(m_rep[0], m_rep[1], m_rep[2]) != 3'b000));
            chk("wr_ready_o", 32'(wr_ready), 32'(!m_corr));
            chk("corrected_o", 32'(corrected), 32'(m_corr));
            chk("err_rep_o", 32'(err_rep), 32'(m_err));
            chk("corr_cnt_o", 32'(corr_cnt), 32'(m_cnt));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic inject(input logic [1:0] rep, input logic [15:0] mask);
        inj_valid = 1'b1; inj_rep = rep; inj_mask = mask;
        cyc();
        inj_valid = 1'b0;
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out waiting", name);
    endtask

    // Advance until the model reports the requested timer phase in IDLE
    task automatic wait_phase(input int phase, input string name);
        int n = 0;
        while (!(m_timer == phase && !m_corr) && n < 4 * SP) begin
            cyc();
            n++;
        end
        if (n >= 4 * SP) timeout(name);
    endtask

    task automatic wait_corrected(input string name);
        int n = 0;
        while (corrected !== 1'b1 && n < 4 * SP) begin
            cyc();
            n++;
        end
        if (n >= 4 * SP) timeout(name);
    endtask

    initial begin
        // Reset held for three cycles
        rst_i = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_i = 1'b1;
        cyc();
        chk("rst q", 32'(q), 32'(RSTV));
        chk("rst ready", 32'(wr_ready), 32'(1'b1));
        chk("rst cnt", 32'(corr_cnt), 32'(2'd0));
        chk("rst err", 32'(err_rep), 32'(3'b000));
        chk_en = 1'b1;

        // Plain write, latency 1
        wr_valid = 1'b1; wr_data = 16'hA5C3;
        cyc();
        wr_valid = 1'b0;
        chk("wr q", 32'(q), 32'(16'hA5C3));
        chk("wr mism", 32'(mismatch), 32'(1'b0));
        chk("wr corr", 32'(corrected), 32'(1'b0));

        // Single-bit upset in replica 1 is scrubbed at the next tick
        inject(2'd1, 16'h0001);
        chk("inj mism", 32'(mismatch), 32'(1'b1));
        chk("inj q", 32'(q), 32'(16'hA5C3));
        wait_corrected("scrub1");
        chk("scrub ready", 32'(wr_ready), 32'(1'b0));
        cyc();
        chk("scrub err", 32'(err_rep), 32'(3'b010));
        chk("scrub cnt", 32'(corr_cnt), 32'(2'd1));
        chk("scrub mism", 32'(mismatch), 32'(1'b0));

        // Write on the tick cycle wins over the pending correction
        wait_phase(SP - 2, "phase_w");
        inject(2'd2, 16'hFF00);
        wr_valid = 1'b1; wr_data = 16'h1234;
        cyc();
        wr_valid = 1'b0;
        chk("wtick q", 32'(q), 32'(16'h1234));
        chk("wtick mism", 32'(mismatch), 32'(1'b0));
        repeat (SP + 2) cyc();
        chk("wtick cnt", 32'(corr_cnt), 32'(2'd1));

        // Five scrub rounds saturate the 2-bit counter
        for (int r = 0; r < 5; r++) begin
            inject(2'(r % 3), 16'(1 << r));
            wait_corrected("sat");
            cyc();
            chk("sat cnt", 32'(corr_cnt), 32'((r + 2 > 3) ? 3 : r + 2));
        end
        chk("sat err", 32'(err_rep), 32'(3'b111));

        // Out-of-range replica index is ignored
        inject(2'd3, 16'hFFFF);
        chk("inj3 mism", 32'(mismatch), 32'(1'b0));
        chk("inj3 q", 32'(q), 32'(16'h1234));

        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        chk("clr cnt", 32'(corr_cnt), 32'(2'd0));
        chk("clr err", 32'(err_rep), 32'(3'b000));

        // Write held across a CORRECT cycle is accepted afterwards
        inject(2'd0, 16'h0010);
        wait_phase(SP - 1, "phase_h");
        cyc();
        chk("hold corr", 32'(corrected), 32'(1'b1));
        chk("hold ready", 32'(wr_ready), 32'(1'b0));
        wr_valid = 1'b1; wr_data = 16'hBEEF;
        cyc();
        chk("hold q0", 32'(q), 32'(16'h1234));
        chk("hold ready1", 32'(wr_ready), 32'(1'b1));
        cyc();
        wr_valid = 1'b0;
        chk("hold q", 32'(q), 32'(16'hBEEF));
        chk("hold cnt", 32'(corr_cnt), 32'(2'd1));
        chk("hold err", 32'(err_rep), 32'(3'b001));

        // Clear in the same cycle as a correction: correction wins
        inject(2'd2, 16'h0100);
        wait_phase(SP - 1, "phase_c");
        cyc();
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        chk("clrcor err", 32'(err_rep), 32'(3'b100));
        chk("clrcor cnt", 32'(corr_cnt), 32'(2'd1));

        // Reset during CORRECT restores everything with no pulse
        inject(2'd1, 16'h0002);
        wait_phase(SP - 1, "phase_r");
        cyc();
        chk("rc corr", 32'(corrected), 32'(1'b1));
        chk_en = 1'b0;
        #2 rst_i = 1'b0;
        #1;
        chk("rc corr0", 32'(corrected), 32'(1'b0));
        chk("rc q", 32'(q), 32'(RSTV));
        chk("rc cnt", 32'(corr_cnt), 32'(2'd0));
        repeat (2) @(posedge clk);
        #3 rst_i = 1'b1;
        cyc();
        chk_en = 1'b1;
        chk("rc ready", 32'(wr_ready), 32'(1'b1));
        chk("rc err", 32'(err_rep), 32'(3'b000));
        repeat (3) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
